// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, FSM state type and the
// alignment rule used when a request is accepted.
package mem_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_WRITE  = 2'd2,
      S_DONE   = 2'd3
   } state_e;

   // The reserved encoding 2'b11 behaves exactly like a word access.
   function automatic logic [1:0] norm_size(input logic [1:0] size);
      return (size == 2'b11) ? SIZE_WORD : size;
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
      logic [1:0] sz;
      sz = norm_size(size);
      if (sz == SIZE_HALF) return offset[0];
      if (sz == SIZE_WORD) return (offset != 2'b00);
      return 1'b0;
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Bus bundle for mem_access_unit: CPU-side request/response plus the word-wide MEM port.
//   slave  : the load/store unit (consumes requests, drives MEM address/data/write)
//   master : the CPU datapath and MEM model around it
interface mem_access_unit_if #(
   parameter int unsigned ADDR_W = 10
);
   logic              req;
   logic              is_store;
   logic [1:0]        size;
   logic              sign_ext;
   logic [31:0]       addr;
   logic [31:0]       wdata;
   logic              ready;
   logic              done;
   logic [31:0]       rdata;
   logic              err;
   logic [ADDR_W-1:0] mem_address;
   logic [31:0]       mem_wdata;
   logic              mem_wr;
   logic [31:0]       mem_rdata;

   modport slave (
      input  req, is_store, size, sign_ext, addr, wdata, mem_rdata,
      output ready, done, rdata, err, mem_address, mem_wdata, mem_wr
   );

   modport master (
      output req, is_store, size, sign_ext, addr, wdata, mem_rdata,
      input  ready, done, rdata, err, mem_address, mem_wdata, mem_wr
   );
endinterface

// File: rtl/mem_byte_lane.sv
// Combinational lane logic for the load/store unit.
//   size_i     : access size (byte/half/word)
//   offset_i   : byte offset within the word
//   sign_ext_i : sign-extend loaded byte/half
//   word_i     : word read from MEM
//   wdata_i    : right-justified store data
//   load_o     : extracted and extended load result
//   merge_o    : word_i with the addressed lane replaced by wdata_i (wdata_i for word size)
module mem_byte_lane
   import mem_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  offset_i,
   input  logic        sign_ext_i,
   input  logic [31:0] word_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_o,
   output logic [31:0] merge_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word_i[{offset_i, 3'b000} +: 8];
      half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
      load_o   = word_i;
      merge_o  = wdata_i;
      case (size_i)
         SIZE_BYTE: begin
            load_o  = {{24{sign_ext_i & byte_sel[7]}}, byte_sel};
            merge_o = word_i;
            merge_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
         end
         SIZE_HALF: begin
            load_o  = {{16{sign_ext_i & half_sel[15]}}, half_sel};
            merge_o = word_i;
            merge_o[{offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator between the CPU datapath and a word-wide data memory.
// Byte-addressed LW/LH/LHU/LB/LBU/SW/SH/SB requests become word accesses; sub-word stores use
// read-modify-write. Ports:
//   clk, rst : system clock, synchronous active-high reset
//   bus      : slave side of mem_access_unit_if (request/response and MEM port)
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
) (
   input logic                clk,
   input logic                rst,
   mem_access_unit_if.slave   bus
);

   state_e            state_q, state_d;
   logic              is_store_q, is_store_d;
   logic [1:0]        size_q, size_d;
   logic              sign_ext_q, sign_ext_d;
   logic [ADDR_W+1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              err_q, err_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [31:0]       merge_q, merge_d;
   logic              mem_wr;
   logic [31:0]       mem_wdata;
   logic [31:0]       lane_load, lane_merge;
   logic              misaligned;

   // Address bits above the MEM word index carry no meaning here.
   logic unused_addr;
   assign unused_addr = ^bus.addr[31:ADDR_W+2];

   mem_byte_lane u_lane (
      .size_i     (size_q),
      .offset_i   (addr_q[1:0]),
      .sign_ext_i (sign_ext_q),
      .word_i     (bus.mem_rdata),
      .wdata_i    (wdata_q),
      .load_o     (lane_load),
      .merge_o    (lane_merge)
   );

   assign misaligned = is_misaligned(bus.size, bus.addr[1:0]);

   always_comb begin
      state_d    = state_q;
      is_store_d = is_store_q;
      size_d     = size_q;
      sign_ext_d = sign_ext_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      err_d      = err_q;
      rdata_d    = rdata_q;
      merge_d    = merge_q;
      mem_wr     = 1'b0;
      mem_wdata  = '0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.req) begin
               is_store_d = bus.is_store;
               size_d     = norm_size(bus.size);
               sign_ext_d = bus.sign_ext;
               addr_d     = bus.addr[ADDR_W+1:0];
               wdata_d    = bus.wdata;
               err_d      = misaligned;
               state_d    = misaligned ? S_DONE : S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (!is_store_q) begin
               rdata_d = lane_load;
               state_d = S_DONE;
            end else if (size_q == SIZE_WORD) begin
               mem_wr    = 1'b1;
               mem_wdata = wdata_q;
               state_d   = S_DONE;
            end else begin
               merge_d = lane_merge;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            mem_wr    = 1'b1;
            mem_wdata = merge_q;
            state_d   = S_DONE;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // MEM samples its write enable on the same edge that resets us.
      if (rst) mem_wr = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         is_store_q <= 1'b0;
         size_q     <= SIZE_BYTE;
         sign_ext_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         err_q      <= 1'b0;
         rdata_q    <= '0;
         merge_q    <= '0;
      end else begin
         state_q    <= state_d;
         is_store_q <= is_store_d;
         size_q     <= size_d;
         sign_ext_q <= sign_ext_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         err_q      <= err_d;
         rdata_q    <= rdata_d;
         merge_q    <= merge_d;
      end
   end

   assign bus.ready       = (state_q == S_IDLE);
   assign bus.done        = (state_q == S_DONE);
   assign bus.err         = (state_q == S_DONE) & err_q;
   assign bus.rdata       = rdata_q;
   assign bus.mem_address = addr_q[ADDR_W+1:2];
   assign bus.mem_wdata   = mem_wdata;
   assign bus.mem_wr      = mem_wr;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic mem_clr = 1'b1;
   int   errors = 0;
   int   checks = 0;
   int   wr_count = 0;

   logic [31:0] tb_mem  [1024];
   logic [31:0] ref_mem [1024];
   logic [31:0] ref_rdata = '0;

   always #5 clk = ~clk;

   mem_access_unit_if #(.ADDR_W(10)) bus ();

   mem_access_unit #(.ADDR_W(10)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Behavioural MEM: combinational read, write on posedge.
   assign bus.mem_rdata = tb_mem[bus.mem_address];

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 1024; i++) tb_mem[i] <= '0;
      end else if (bus.mem_wr) begin
         tb_mem[bus.mem_address] <= bus.mem_wdata;
         wr_count <= wr_count + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic misal(input logic [1:0] sz, input logic [31:0] a);
      if (sz == 2'd1) return a[0];
      if (sz >= 2'd2) return a[1:0] != 2'b00;
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [1:0] off, input logic sx);
      logic [31:0] v;
      int sh;
      sh = 8 * int'(off);
      if (sz == 2'd0) begin
         v = (w >> sh) & 32'hFF;
         if (sx && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
         v = (w >> sh) & 32'hFFFF;
         if (sx && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end else begin
         v = w;
      end
      return v;
   endfunction

   function automatic logic [31:0] model_store(input logic [31:0] w, input logic [1:0] sz,
                                               input logic [1:0] off, input logic [31:0] wd);
      logic [31:0] mask;
      int sh;
      sh = 8 * int'(off);
      if (sz >= 2'd2) return wd;
      mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
      return (w & ~mask) | ((wd << sh) & mask);
   endfunction

   // Entered #1 after a posedge with the DUT idle; leaves #1 after the edge following done.
   task automatic run_op(input string tag, input logic st, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd);
      int lat;
      int wr0;
      int idx;
      int exp_lat;
      logic mis;
      idx = int'(a[11:2]);
      mis = misal(sz, a);
      exp_lat = mis ? 1 : (!st || sz >= 2'd2) ? 2 : 3;
      check({tag, "_ready"}, {31'b0, bus.ready}, 32'd1);
      wr0 = wr_count;
      bus.req = 1'b1;
      bus.is_store = st;
      bus.size = sz;
      bus.sign_ext = sx;
      bus.addr = a;
      bus.wdata = wd;
      @(posedge clk);
      #1;
      bus.req = 1'b0;
      bus.addr = $urandom();
      bus.wdata = $urandom();
      lat = 1;
      while (!bus.done && lat < 8) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!mis && st) ref_mem[idx] = model_store(ref_mem[idx], sz, a[1:0], wd);
      if (!mis && !st) ref_rdata = model_load(ref_mem[idx], sz, a[1:0], sx);
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_err"}, {31'b0, bus.err}, {31'b0, mis});
      check({tag, "_rdata"}, bus.rdata, ref_rdata);
      check({tag, "_wr_pulses"}, wr_count - wr0, (st && !mis) ? 1 : 0);
      check({tag, "_mem"}, tb_mem[idx], ref_mem[idx]);
      @(posedge clk);
      #1;
      check({tag, "_done_pulse"}, {31'b0, bus.done}, 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, {31'b0, bus.ready}, 32'd1);
      check({tag, "_done"}, {31'b0, bus.done}, 32'd0);
      check({tag, "_err"}, {31'b0, bus.err}, 32'd0);
      check({tag, "_rdata"}, bus.rdata, 32'd0);
      check({tag, "_mem_wr"}, {31'b0, bus.mem_wr}, 32'd0);
      check({tag, "_mem_address"}, {22'b0, bus.mem_address}, 32'd0);
      check({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
   endtask

   initial begin
      int wr0;
      logic [31:0] a;
      for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
      bus.req = 1'b0;
      bus.is_store = 1'b0;
      bus.size = 2'd0;
      bus.sign_ext = 1'b0;
      bus.addr = '0;
      bus.wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;
      mem_clr = 1'b0;

      // Word store then sub-word loads of the same word.
      run_op("sw", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
      check("sw_word4", tb_mem[4], 32'hDEAD_BEEF);
      run_op("lb", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
      check("lb_value", bus.rdata, 32'hFFFF_FFDE);
      run_op("lbu", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
      check("lbu_value", bus.rdata, 32'h0000_00DE);
      run_op("lh", 1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
      check("lh_value", bus.rdata, 32'hFFFF_DEAD);
      run_op("lhu", 1'b0, 2'd1, 1'b0, 32'h10, 32'h0);
      check("lhu_value", bus.rdata, 32'h0000_BEEF);

      // Read-modify-write stores.
      run_op("sb", 1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00AA);
      check("sb_word4", tb_mem[4], 32'hDEAD_AAEF);
      run_op("sh", 1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_1234);
      check("sh_word4", tb_mem[4], 32'h1234_AAEF);

      // Misaligned accesses.
      run_op("sh_mis", 1'b1, 2'd1, 1'b0, 32'h13, 32'hFFFF_FFFF);
      run_op("lw_mis", 1'b0, 2'd2, 1'b0, 32'h12, 32'h0);
      check("mis_word4", tb_mem[4], 32'h1234_AAEF);
      run_op("ill_size", 1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
      check("ill_size_value", bus.rdata, 32'h1234_AAEF);

      // Reset in the WRITE cycle of an SB must not write MEM.
      wr0 = wr_count;
      bus.req = 1'b1;
      bus.is_store = 1'b1;
      bus.size = 2'd0;
      bus.addr = 32'h10;
      bus.wdata = 32'h0000_0077;
      @(posedge clk);
      #1;
      bus.req = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("rst_wr_gated", {31'b0, bus.mem_wr}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      ref_rdata = '0;
      check_reset_outputs("rst_abort");
      check("rst_abort_word4", tb_mem[4], 32'h1234_AAEF);
      check("rst_abort_wr", wr_count - wr0, 0);

      // req held through a busy SB: only one op; LW accepted in the IDLE cycle after DONE.
      wr0 = wr_count;
      bus.req = 1'b1;
      bus.is_store = 1'b1;
      bus.size = 2'd0;
      bus.addr = 32'h16;
      bus.wdata = 32'h0000_0055;
      @(posedge clk);
      #1;
      check("held_busy", {31'b0, bus.ready}, 32'd0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check("held_done", {31'b0, bus.done}, 32'd1);
      bus.req = 1'b0;
      ref_mem[5] = model_store(ref_mem[5], 2'd0, 2'd2, 32'h55);
      check("held_one_write", wr_count - wr0, 1);
      check("held_word5", tb_mem[5], 32'h0055_0000);
      @(posedge clk);
      #1;
      run_op("lw_b2b", 1'b0, 2'd2, 1'b0, 32'h14, 32'h0);

      // Random mix over words 4..7 with random upper address bits.
      for (int n = 0; n < 40; n++) begin
         a = $urandom();
         a[11:4] = 8'h01;
         run_op("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), a, $urandom());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
